// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data-cache controller with a blocking miss FSM.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_controller #(
    parameter int SETS  = 16,
    parameter int MEM_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic [31:0]       mem_addr_o,
    output logic [MEM_W-1:0]  mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [MEM_W-1:0]  mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = 27 - INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS,
        S_WRITEBACK,
        S_READMISS,
        S_READMISSOK
    } state_t;

    state_t             state_q, state_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [SETS-1:0]    dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_mem [SETS];
    logic [MEM_W-1:0]   data_mem [SETS];
    logic               mem_enable_q, mem_enable_d;
    logic               mem_write_q, mem_write_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [MEM_W-1:0]   mem_data_q, mem_data_d;

    logic               req_s, hit_s, victim_dirty_s;
    logic               line_we_s, tag_we_s;
    logic [MEM_W-1:0]   line_s, line_wdata_s;
    logic [INDEX_W-1:0] req_index_s;
    logic [TAG_W-1:0]   req_tag_s;
    logic [2:0]         word_sel_s;
    logic [1:0]         unused_addr_s;

    assign unused_addr_s  = cpu_addr_i[1:0];
    assign req_s          = cpu_MemRead_i | cpu_MemWrite_i;
    assign req_index_s    = cpu_addr_i[4+INDEX_W:5];
    assign req_tag_s      = cpu_addr_i[31:5+INDEX_W];
    assign word_sel_s     = cpu_addr_i[4:2];
    assign line_s         = data_mem[req_index_s];
    assign hit_s          = (state_q == S_IDLE) & valid_q[req_index_s] & (tag_mem[req_index_s] == req_tag_s);
    assign victim_dirty_s = valid_q[req_index_s] & dirty_q[req_index_s];

    // Gate the read word with hit so an untouched array never leaks X onto the bus.
    assign cpu_data_o   = hit_s ? line_s[{word_sel_s, 5'b00000} +: 32] : 32'h0000_0000;
    assign cpu_stall_o  = (req_s & ~hit_s) | (state_q != S_IDLE);
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    // Next-state, line update and memory-request computation.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        line_we_s    = 1'b0;
        tag_we_s     = 1'b0;
        line_wdata_s = line_s;
        mem_enable_d = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;

        case (state_q)
            S_IDLE: begin
                if (req_s && hit_s) begin
                    if (cpu_MemWrite_i) begin
                        line_wdata_s[{word_sel_s, 5'b00000} +: 32] = cpu_data_i;
                        line_we_s                = 1'b1;
                        dirty_d[req_index_s]     = 1'b1;
                    end else begin
                        line_we_s = 1'b0;
                    end
                end else if (req_s) begin
                    state_d = S_MISS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MISS: begin
                state_d = victim_dirty_s ? S_WRITEBACK : S_READMISS;
            end
            S_WRITEBACK: begin
                state_d = mem_ack_i ? S_READMISS : S_WRITEBACK;
            end
            S_READMISS: begin
                if (mem_ack_i) begin
                    state_d              = S_READMISSOK;
                    line_wdata_s         = mem_data_i;
                    line_we_s            = 1'b1;
                    tag_we_s             = 1'b1;
                    valid_d[req_index_s] = 1'b1;
                    dirty_d[req_index_s] = 1'b0;
                end else begin
                    state_d = S_READMISS;
                end
            end
            S_READMISSOK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Memory request is registered from the next state so it is high on entry.
        case (state_d)
            S_WRITEBACK: begin
                mem_enable_d = 1'b1;
                mem_write_d  = 1'b1;
                mem_addr_d   = {tag_mem[req_index_s], req_index_s, 5'b00000};
                mem_data_d   = line_s;
            end
            S_READMISS: begin
                mem_enable_d = 1'b1;
                mem_write_d  = 1'b0;
                mem_addr_d   = {req_tag_s, req_index_s, 5'b00000};
            end
            default: begin
                mem_enable_d = 1'b0;
                mem_write_d  = 1'b0;
            end
        endcase
    end

    // Control state and memory-interface registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits guard their contents.
    always_ff @(posedge clk_i) begin
        if (line_we_s) begin
            data_mem[req_index_s] <= line_wdata_s;
        end
        if (tag_we_s) begin
            tag_mem[req_index_s] <= req_tag_s;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        refilled_q, refilled_d;

    // The first IDLE cycle after a refill is the retried request, not a fresh hit.
    always_comb begin
        refilled_d = (state_q == S_READMISSOK);
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (req_s && hit_s && !refilled_q) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
        if ((state_q == S_IDLE) && (state_d == S_MISS)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
            refilled_q <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            refilled_q <= refilled_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed vector table, reset-during-refill
// sequence, and random traffic against a line-level cache/memory reference model.
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         mem_read, mem_wr, cpu_stall;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_rdata;
    logic         mem_enable_o, mem_write_o, mem_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cpu_addr_i     (cpu_addr),
        .cpu_data_i     (cpu_wdata),
        .cpu_MemRead_i  (mem_read),
        .cpu_MemWrite_i (mem_wr),
        .cpu_data_o     (cpu_rdata),
        .cpu_stall_o    (cpu_stall),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_data_i     (mem_rdata),
        .mem_ack_i      (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o      (hit_cnt),
        .miss_cnt_o     (miss_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Off-chip memory seen by the DUT, and the reference copy of what memory should hold.
    logic [255:0] mem_model [256];
    logic [255:0] ref_mem   [256];

    // Reference cache state.
    bit           ref_valid [16];
    bit           ref_dirty [16];
    logic [22:0]  ref_tag   [16];
    logic [255:0] ref_line  [16];
    int           exp_hits, exp_misses;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int line, input int w);
        return 32'h1000_0000 | 32'(line << 8) | 32'(w);
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < 16; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; mem_read = 1'b0; mem_wr = 1'b0; mem_ack = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ref_reset();
    endtask

    // Reference: one CPU access, computed at line granularity.
    task automatic ref_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input int wlat, input int rlat,
                              output int exp_stall, output logic [31:0] exp_data,
                              output bit exp_wb, output logic [31:0] exp_wb_addr,
                              output logic [255:0] exp_wb_data);
        int idx, w;
        idx = int'(addr[8:5]);
        w   = int'(addr[4:2]);
        exp_wb = 1'b0; exp_wb_addr = 32'h0; exp_wb_data = '0;
        if (ref_valid[idx] && ref_tag[idx] == addr[31:9]) begin
            exp_stall = 0;
            exp_hits++;
        end else begin
            exp_misses++;
            exp_stall = rlat + 4;
            if (ref_valid[idx] && ref_dirty[idx]) begin
                exp_stall   = exp_stall + wlat + 1;
                exp_wb      = 1'b1;
                exp_wb_addr = {ref_tag[idx], 4'(idx), 5'b00000};
                exp_wb_data = ref_line[idx];
                ref_mem[exp_wb_addr[12:5]] = ref_line[idx];
            end
            ref_line[idx]  = ref_mem[addr[12:5]];
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = addr[31:9];
            ref_dirty[idx] = 1'b0;
        end
        exp_data = ref_line[idx][w*32 +: 32];
        if (we) begin
            ref_line[idx][w*32 +: 32] = wdata;
            ref_dirty[idx] = 1'b1;
        end
    endtask

    // Issue one request and act as the slow memory until it completes. Called at posedge+1.
    task automatic do_req(input bit we, input bit both, input logic [31:0] addr, input logic [31:0] wdata,
                          input int wlat, input int rlat,
                          output int stalls, output logic [31:0] rdata,
                          output bit wb_seen, output logic [31:0] wb_addr, output logic [255:0] wb_data,
                          output logic [31:0] rd_addr);
        int k, lat;
        bit timed_out;
        cpu_addr = addr; cpu_wdata = wdata;
        mem_wr   = we;
        mem_read = !we || both;
        stalls = 0; k = 0; wb_seen = 1'b0; wb_addr = 32'h0; wb_data = '0; rd_addr = 32'hFFFF_FFFF;
        timed_out = 1'b0;
        forever begin
            #1;
            if (!cpu_stall) break;
            stalls++;
            if (stalls > 300) begin
                timed_out = 1'b1;
                break;
            end
            if (mem_enable_o) begin
                lat = mem_write_o ? wlat : rlat;
                if (k == lat) begin
                    mem_ack = 1'b1;
                    k = 0;
                    if (mem_write_o) begin
                        wb_seen = 1'b1; wb_addr = mem_addr_o; wb_data = mem_data_o;
                        mem_model[mem_addr_o[12:5]] = mem_data_o;
                    end else begin
                        rd_addr   = mem_addr_o;
                        mem_rdata = mem_model[mem_addr_o[12:5]];
                    end
                end else begin
                    mem_ack = 1'b0;
                    k++;
                end
            end else begin
                mem_ack = 1'b0;
            end
            @(posedge clk);
            #1 mem_ack = 1'b0;
        end
        rdata = cpu_rdata;
        if (timed_out) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: addr %h still stalled after %0d cycles, required completion", addr, stalls);
            apply_reset();
        end else begin
            @(posedge clk);
            #1;
        end
        mem_read = 1'b0; mem_wr = 1'b0;
    endtask

    typedef struct {
        bit          we;
        bit          both;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wlat;
        int          rlat;
        int          exp_stall;
        logic [31:0] exp_data;
        logic [31:0] exp_wb_addr;   // all ones: no write-back expected
        int          chk_word;
        logic [31:0] chk_val;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int           stalls, e_stall;
        logic [31:0]  rdata, wb_addr, rd_addr, e_data, e_wb_addr;
        logic [255:0] wb_data, e_wb_data;
        bit           wb_seen, e_wb;
        logic [31:0]  none;
        int           cnt;

        none = 32'hFFFF_FFFF;
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,          0, 10, 14, 32'd5,        none,          0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,          0, 0,  0,  32'd0,        none,          0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0008, 32'hDEADBEEF,   0, 0,  0,  32'h0,        none,          0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0208, 32'h0,          3, 2,  10, 32'h1000_1002, 32'h0000_0000, 2, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,          0, 1,  5,  32'h1000_0200, none,          0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_1234,  0, 0,  0,  32'h0,        none,          0, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,          0, 0,  0,  32'h0000_1234, none,          0, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_0044, 32'h0000_0055,  0, 0,  0,  32'h0,        none,          0, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_0440, 32'h0,          0, 0,  5,  32'h1000_2200, 32'h0000_0040, 1, 32'h0000_0055};

        for (int l = 0; l < 256; l++)
            for (int w = 0; w < 8; w++)
                mem_model[l][w*32 +: 32] = pat(l, w);
        mem_model[0] = 256'd5;
        for (int l = 0; l < 256; l++) ref_mem[l] = mem_model[l];

        apply_reset();
        #1;
        check32("rst_stall",      {31'b0, cpu_stall}, 32'd0);
        check32("rst_mem_enable", {31'b0, mem_enable_o}, 32'd0);
        check32("rst_mem_write",  {31'b0, mem_write_o}, 32'd0);
        check32("rst_mem_addr",   mem_addr_o, 32'h0);
        check256("rst_mem_data",  mem_data_o, 256'h0);
        check32("rst_cpu_data",   cpu_rdata, 32'h0);
`ifdef DCACHE_STATS_EN
        check32("rst_hit_cnt",  hit_cnt, 32'd0);
        check32("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            ref_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wlat, vecs[i].rlat,
                       e_stall, e_data, e_wb, e_wb_addr, e_wb_data);
            do_req(vecs[i].we, vecs[i].both, vecs[i].addr, vecs[i].wdata, vecs[i].wlat, vecs[i].rlat,
                   stalls, rdata, wb_seen, wb_addr, wb_data, rd_addr);
            check32($sformatf("vec%0d_stall", i), 32'(stalls), 32'(vecs[i].exp_stall));
            if (!vecs[i].we) check32($sformatf("vec%0d_data", i), rdata, vecs[i].exp_data);
            check32($sformatf("vec%0d_wb_seen", i), {31'b0, wb_seen}, {31'b0, vecs[i].exp_wb_addr != none});
            if (vecs[i].exp_wb_addr != none) begin
                check32($sformatf("vec%0d_wb_addr", i), wb_addr, vecs[i].exp_wb_addr);
                check32($sformatf("vec%0d_wb_word", i), wb_data[vecs[i].chk_word*32 +: 32], vecs[i].chk_val);
            end
            if (vecs[i].exp_stall != 0)
                check32($sformatf("vec%0d_rd_addr", i), rd_addr, {vecs[i].addr[31:5], 5'b00000});
        end
`ifdef DCACHE_STATS_EN
        check32("dir_hit_cnt",  hit_cnt, 32'd5);
        check32("dir_miss_cnt", miss_cnt, 32'd4);
`endif

        // Reset while a refill is outstanding, then a stray ack.
        cpu_addr = 32'h0000_0080; mem_read = 1'b1;
        cnt = 0;
        while (!mem_enable_o && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check32("midrst_reached_readmiss", {31'b0, mem_enable_o & ~mem_write_o}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check32("midrst_enable_drop", {31'b0, mem_enable_o}, 32'd0);
        check32("midrst_write_low",   {31'b0, mem_write_o}, 32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0; rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = {8{32'hBADBAD00}};
        @(posedge clk); #1;
        mem_ack = 1'b0;
        #1;
        check32("midrst_enable_after_ack", {31'b0, mem_enable_o}, 32'd0);
        check32("midrst_stall_after_ack",  {31'b0, cpu_stall}, 32'd0);
        @(posedge clk); #1;
        do_req(1'b0, 1'b0, 32'h0000_0080, 32'h0, 0, 2, stalls, rdata, wb_seen, wb_addr, wb_data, rd_addr);
        check32("midrst_reload_stall", 32'(stalls), 32'd6);
        check32("midrst_reload_data",  rdata, 32'h1000_0400);
        check32("midrst_reload_no_wb", {31'b0, wb_seen}, 32'd0);

        // Random traffic over a few sets and tags so conflicts and dirty evictions recur.
        apply_reset();
        for (int l = 0; l < 256; l++) begin
            for (int w = 0; w < 8; w++) mem_model[l][w*32 +: 32] = $urandom;
            ref_mem[l] = mem_model[l];
        end
        @(posedge clk); #1;
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a, d;
            bit we, both;
            int wl, rl;
            a    = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            d    = $urandom;
            we   = $urandom_range(0, 1);
            both = we & ($urandom_range(0, 3) == 0);
            wl   = $urandom_range(0, 4);
            rl   = $urandom_range(0, 4);
            ref_access(we, a, d, wl, rl, e_stall, e_data, e_wb, e_wb_addr, e_wb_data);
            do_req(we, both, a, d, wl, rl, stalls, rdata, wb_seen, wb_addr, wb_data, rd_addr);
            check32($sformatf("rnd%0d_stall", n), 32'(stalls), 32'(e_stall));
            if (!we) check32($sformatf("rnd%0d_data", n), rdata, e_data);
            check32($sformatf("rnd%0d_wb_seen", n), {31'b0, wb_seen}, {31'b0, e_wb});
            if (e_wb) begin
                check32($sformatf("rnd%0d_wb_addr", n), wb_addr, e_wb_addr);
                check256($sformatf("rnd%0d_wb_data", n), wb_data, e_wb_data);
            end
            if (e_stall != 0)
                check32($sformatf("rnd%0d_rd_addr", n), rd_addr, {a[31:5], 5'b00000});
        end
`ifdef DCACHE_STATS_EN
        check32("rnd_hit_cnt",  hit_cnt, 32'(exp_hits));
        check32("rnd_miss_cnt", miss_cnt, 32'(exp_misses));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
